data_port_responder: RTL and testbench

//  Memory-side responder for the core's data interface: services the read port (rce/ra/rq)
//  and write port (wce/wa/wd) from an internal 2^A_WIDTH x D_WIDTH array. Address IO_ADDR is

---
 rtl/data_port_responder.sv | 188 ++++++++++++++++++
 tb/tb_data_port_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_port_responder.sv
// data_port_responder
//   Memory-side responder for the core's data interface. Services a registered
//   read port (rce/ra/rq) and a write port (wce/wa/wd) from an internal
//   2^A_WIDTH x D_WIDTH array. Address IO_ADDR is memory-mapped console I/O:
//   reads pop the input FIFO, writes push the output FIFO.
//
//   Optional feature macro: DATA_PORT_CLEAR_EN
//     defined   : after reset the array is zero-filled one word per cycle while busy=1
//     undefined : busy tied low, array contents undefined after reset
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   rce, ra, rq          read strobe, address, registered read data
//   wce, wa, wd          write strobe, address, data
//   in_data/valid/ready  console input stream into the input FIFO
//   out_data/valid/ready console output stream from the output FIFO
//   in_underflow         sticky: I/O read with input FIFO empty
//   out_overflow         sticky: I/O write dropped, output FIFO full
//   busy                 clear sweep in progress
module data_port_responder #(
    parameter int unsigned        A_WIDTH = 12,
    parameter int unsigned        D_WIDTH = 8,
    parameter logic [A_WIDTH-1:0] IO_ADDR = '1,
    parameter int unsigned        FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rce,
    input  logic [A_WIDTH-1:0] ra,
    output logic [D_WIDTH-1:0] rq,
    input  logic               wce,
    input  logic [A_WIDTH-1:0] wa,
    input  logic [D_WIDTH-1:0] wd,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               in_underflow,
    output logic               out_overflow,
    output logic               busy
);

    localparam int unsigned MEM_DEPTH  = 1 << A_WIDTH;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W      = FIFO_AW + 1;

    logic [D_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [D_WIDTH-1:0] r_rq;

    logic [D_WIDTH-1:0] r_in_buf [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_in_rd, r_in_wr;
    logic [CNT_W-1:0]   r_in_cnt;

    logic [D_WIDTH-1:0] r_out_buf [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_out_rd, r_out_wr;
    logic [CNT_W-1:0]   r_out_cnt;

    logic r_in_underflow, r_out_overflow;

    logic               w_busy;
    logic               w_clr_we;
    logic [A_WIDTH-1:0] w_clr_addr;

    // Zero-fill sweep after reset; a reset mid-sweep restarts it from address 0.
`ifdef DATA_PORT_CLEAR_EN
    logic               r_busy;
    logic [A_WIDTH-1:0] r_clr_addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
        end else if (r_busy) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (&r_clr_addr) r_busy <= 1'b0;
        end
    end

    assign w_busy     = r_busy;
    assign w_clr_we   = r_busy;
    assign w_clr_addr = r_clr_addr;
`else
    assign w_busy     = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    // Strobe decode; the core's ports are ignored during the sweep.
    logic w_io_rd, w_io_wr, w_mem_we;
    logic w_in_empty, w_in_full, w_in_push, w_in_pop;
    logic w_out_full, w_out_push, w_out_pop, w_out_drop;

    assign w_io_rd  = rce && !w_busy && (ra == IO_ADDR);
    assign w_io_wr  = wce && !w_busy && (wa == IO_ADDR);
    assign w_mem_we = wce && !w_busy && (wa != IO_ADDR);

    assign w_in_empty = (r_in_cnt == '0);
    assign w_in_full  = (r_in_cnt == CNT_W'(FIFO_DEPTH));
    assign w_in_push  = in_valid && !w_in_full;
    // Pop decision uses the registered count, so a same-cycle push into an
    // empty FIFO is not visible to the read.
    assign w_in_pop   = w_io_rd && !w_in_empty;

    assign w_out_full = (r_out_cnt == CNT_W'(FIFO_DEPTH));
    assign w_out_pop  = (r_out_cnt != '0) && out_ready;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_out_push = w_io_wr && (!w_out_full || w_out_pop);
    assign w_out_drop = w_io_wr && w_out_full && !w_out_pop;

    // Storage array: sweep writes take priority (core is held off anyway).
    always_ff @(posedge clk) begin
        if (w_clr_we)      r_mem[w_clr_addr] <= '0;
        else if (w_mem_we) r_mem[wa]         <= wd;
    end

    // Read data register with write-to-read bypass for memory addresses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rq <= '0;
        end else if (rce && !w_busy) begin
            if (ra == IO_ADDR)        r_rq <= w_in_empty ? '0 : r_in_buf[r_in_rd];
            else if (wce && wa == ra) r_rq <= wd;
            else                      r_rq <= r_mem[ra];
        end
    end

    // FIFO payload storage; not reset, contents qualified by the counts.
    always_ff @(posedge clk) begin
        if (w_in_push)  r_in_buf[r_in_wr]   <= in_data;
        if (w_out_push) r_out_buf[r_out_wr] <= wd;
    end

    // Input FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_rd  <= '0;
            r_in_wr  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + 1'b1;
            if (w_in_pop)  r_in_rd <= r_in_rd + 1'b1;
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + CNT_W'(1);
                2'b01:   r_in_cnt <= r_in_cnt - CNT_W'(1);
                default: r_in_cnt <= r_in_cnt;
            endcase
        end
    end

    // Output FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_rd  <= '0;
            r_out_wr  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) r_out_wr <= r_out_wr + 1'b1;
            if (w_out_pop)  r_out_rd <= r_out_rd + 1'b1;
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
                2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_underflow <= 1'b0;
            r_out_overflow <= 1'b0;
        end else begin
            if (w_io_rd && w_in_empty) r_in_underflow <= 1'b1;
            if (w_out_drop)            r_out_overflow <= 1'b1;
        end
    end

    assign rq           = r_rq;
    assign in_ready     = !w_in_full;
    assign out_data     = r_out_buf[r_out_rd];
    assign out_valid    = (r_out_cnt != '0);
    assign in_underflow = r_in_underflow;
    assign out_overflow = r_out_overflow;
    assign busy         = w_busy;

endmodule

// File: tb/tb_data_port_responder.sv
// Scoreboard bench for data_port_responder: stimulus pushes expected rq and
// out_data values into queues, a monitor pops and compares them mid-cycle.
module tb_data_port_responder;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;
    localparam logic [AW-1:0] IO = 12'hFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          rce, wce, in_valid, out_ready;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd, in_data;
    logic [DW-1:0] rq, out_data;
    logic          in_ready, out_valid, in_underflow, out_overflow, busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rq_q[$];
    logic [DW-1:0] out_q[$];
    logic          pend;

    data_port_responder dut (
        .clk          (clk),
        .reset        (reset),
        .rce          (rce),
        .ra           (ra),
        .rq           (rq),
        .wce          (wce),
        .wa           (wa),
        .wd           (wd),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .in_underflow (in_underflow),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until busy drops (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 10000) begin
            tick();
            n++;
        end
    endtask

    // Monitor: note read strobes at the edge, compare rq and out_data mid-cycle.
    always begin
        @(posedge clk);
        pend = rce && !busy && reset;
        @(negedge clk);
        if (pend) begin
            if (rq_q.size() == 0) begin
                check("rq_unexpected", 32'(rq), 32'hDEAD);
            end else begin
                check("rq", 32'(rq), 32'(rq_q[0]));
                void'(rq_q.pop_front());
            end
        end
        if (out_valid && out_ready) begin
            if (out_q.size() == 0) begin
                check("out_unexpected", 32'(out_data), 32'hDEAD);
            end else begin
                check("out_data", 32'(out_data), 32'(out_q[0]));
                void'(out_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        reset = 1'b0; rce = 1'b0; wce = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ra = '0; wa = '0; wd = '0; in_data = '0;
        repeat (2) tick();
        reset = 1'b1;

        check("rst_rq", 32'(rq), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_underflow", 32'(in_underflow), 32'h0);
        check("rst_out_overflow", 32'(out_overflow), 32'h0);
        wait_idle(n);
`ifdef DATA_PORT_CLEAR_EN
        check("sweep_len", 32'(n), 32'd4096);
`else
        check("busy_idle", 32'(busy), 32'h0);
`endif

        // Write then read back
        wce = 1'b1; wa = 12'd5; wd = 8'h2A; tick();
        wce = 1'b0; rce = 1'b1; ra = 12'd5; rq_q.push_back(8'h2A); tick();
        rce = 1'b0; tick();

        // Same-cycle write/read bypass, then plain read of the stored value
        wce = 1'b1; wa = 12'd7; wd = 8'h11; rce = 1'b1; ra = 12'd7; rq_q.push_back(8'h11); tick();
        wce = 1'b0; rq_q.push_back(8'h11); tick();
        rce = 1'b0; tick();

        // Address just below IO_ADDR is ordinary memory
        wce = 1'b1; wa = 12'hFFE; wd = 8'h3C; tick();
        wce = 1'b0; rce = 1'b1; ra = 12'hFFE; rq_q.push_back(8'h3C); tick();
        rce = 1'b0; tick();

        // Input FIFO pops, then underflow
        in_valid = 1'b1; in_data = 8'h41; tick();
        in_data = 8'h42; tick();
        in_valid = 1'b0;
        rce = 1'b1; ra = IO;
        rq_q.push_back(8'h41); tick();
        rq_q.push_back(8'h42); tick();
        check("no_underflow_yet", 32'(in_underflow), 32'h0);
        rq_q.push_back(8'h00); tick();
        rce = 1'b0;
        check("underflow_set", 32'(in_underflow), 32'h1);

        // Output FIFO overflow and drain
        out_ready = 1'b0; wce = 1'b1; wa = IO;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) check("no_overflow_yet", 32'(out_overflow), 32'h0);
            wd = 8'(i);
            tick();
        end
        wce = 1'b0;
        check("overflow_set", 32'(out_overflow), 32'h1);
        check("out_valid_full", 32'(out_valid), 32'h1);
        for (int i = 1; i <= 4; i++) out_q.push_back(8'(i));
        out_ready = 1'b1;
        repeat (4) tick();
        check("out_valid_drained", 32'(out_valid), 32'h0);
        check("out_q_drained", 32'(out_q.size()), 32'h0);
        out_ready = 1'b0;

        // Full input FIFO, IO read with in_valid held
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
        end
        check("in_full", 32'(in_ready), 32'h0);
        in_data = 8'h14; rce = 1'b1; ra = IO; rq_q.push_back(8'h10); tick();
        rce = 1'b0; tick();
        in_valid = 1'b0;
        check("in_refull", 32'(in_ready), 32'h0);
        rce = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            rq_q.push_back(8'h10 + 8'(i));
            tick();
        end
        rce = 1'b0;
        check("in_empty_ready", 32'(in_ready), 32'h1);

        // Push into empty FIFO with same-cycle pop: no fall-through
        in_valid = 1'b1; in_data = 8'h77; rce = 1'b1; ra = IO; rq_q.push_back(8'h00); tick();
        in_valid = 1'b0; rq_q.push_back(8'h77); tick();
        rce = 1'b0; tick();

        // Same-cycle IO read and IO write are independent
        in_valid = 1'b1; in_data = 8'h55; tick();
        in_valid = 1'b0;
        rce = 1'b1; ra = IO; wce = 1'b1; wa = IO; wd = 8'h66; rq_q.push_back(8'h55); tick();
        rce = 1'b0; wce = 1'b0;
        check("io_rw_out_valid", 32'(out_valid), 32'h1);
        out_q.push_back(8'h66); out_ready = 1'b1; tick();
        out_ready = 1'b0;
        check("io_rw_out_empty", 32'(out_valid), 32'h0);

        // Full output FIFO accepts a write when its head leaves the same cycle
        wce = 1'b1; wa = IO;
        for (int i = 0; i < 4; i++) begin
            wd = 8'hA0 + 8'(i);
            tick();
        end
        for (int i = 0; i < 5; i++) out_q.push_back(8'hA0 + 8'(i));
        wd = 8'hA4; out_ready = 1'b1; tick();
        wce = 1'b0;
        repeat (4) tick();
        check("full_pop_push_empty", 32'(out_valid), 32'h0);
        check("full_pop_push_q", 32'(out_q.size()), 32'h0);
        out_ready = 1'b0;

`ifdef DATA_PORT_CLEAR_EN
        // Sweep clears array; reset mid-sweep restarts the full sweep
        wce = 1'b1; wa = 12'h123; wd = 8'h55; tick();
        wce = 1'b0; rce = 1'b1; ra = 12'h123; rq_q.push_back(8'h55); tick();
        rce = 1'b0;
        reset = 1'b0; tick();
        reset = 1'b1;
        rce = 1'b1; ra = 12'd5; tick();
        rce = 1'b0;
        check("busy_rq_hold", 32'(rq), 32'h0);
        check("busy_out_idle", 32'(out_valid), 32'h0);
        wait_idle(n);
        check("sweep_len_2", 32'(n + 1), 32'd4096);
        rce = 1'b1; ra = 12'h123; rq_q.push_back(8'h00); tick();
        rce = 1'b0;
        reset = 1'b0; tick();
        reset = 1'b1;
        repeat (100) tick();
        reset = 1'b0; tick();
        reset = 1'b1;
        wait_idle(n);
        check("sweep_restart_len", 32'(n), 32'd4096);
`endif

        repeat (2) tick();
        check("rq_q_empty", 32'(rq_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
